// File: rtl/threshold_scan_ctrl_pkg.sv
// Shared types and constants for the threshold scan controller.
package threshold_scan_ctrl_pkg;

    localparam int PACK_W_DEF = 8;
    localparam int CNT_W_DEF  = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } scan_state_e;

    localparam logic [2:0] STAGE_COARSE = 3'd1;
    localparam logic [2:0] STAGE_FINE   = 3'd3;
    localparam logic [2:0] STAGE_PEAK   = 3'd4;
    localparam logic [2:0] STAGE_TRACK  = 3'd5;

endpackage

// File: rtl/threshold_scan_ctrl_packer.sv
// Packs comparator result bits LSB-first into PACK_W-bit words and holds
// each completed word in an output register until the consumer takes it.
module result_packer #(
    parameter int PACK_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        bit_vld,
    input  logic                        bit_in,
    input  logic                        flush,
    input  logic                        out_ready,
    output logic [$clog2(PACK_W+1)-1:0] bit_cnt,
    output logic                        out_valid,
    output logic [PACK_W-1:0]           out_data
);
    localparam int BW = $clog2(PACK_W + 1);
    localparam logic [BW-1:0] LAST = BW'(PACK_W - 1);

    logic [PACK_W-1:0] shreg_q, shreg_d, word;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [PACK_W-1:0] dat_q, dat_d;

    always_comb begin
        word = shreg_q;
        for (int i = 0; i < PACK_W; i++)
            if (cnt_q == BW'(i)) word[i] = bit_in;

        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        dat_d   = dat_q;

        if (vld_q && out_ready) vld_d = 1'b0;

        // The controller throttles intake so a completing word always
        // finds the output register empty or draining.
        if (bit_vld) begin
            if (cnt_q == LAST) begin
                vld_d   = 1'b1;
                dat_d   = word;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = word;
                cnt_d   = cnt_q + BW'(1);
            end
        end else if (flush && cnt_q != '0 && (!vld_q || out_ready)) begin
            vld_d   = 1'b1;
            dat_d   = shreg_q;
            shreg_d = '0;
            cnt_d   = '0;
        end

        if (clr) begin
            shreg_d = '0;
            cnt_d   = '0;
            vld_d   = 1'b0;
            dat_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

    assign bit_cnt   = cnt_q;
    assign out_valid = vld_q;
    assign out_data  = dat_q;

endmodule

// File: rtl/threshold_scan_ctrl.sv
// Frame controller: streams STFT magnitudes to an external comparator,
// collects its registered result bits and emits them as packed words.
module threshold_scan_ctrl
    import threshold_scan_ctrl_pkg::*;
#(
    parameter int IL        = 10,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FRAME_LEN = 16384,
    parameter int PACK_W    = PACK_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iSTART,
    input  logic [2:0]        iSTAGE,
    input  logic              iABORT,
    input  logic              iVALID,
    input  logic [IL-1:0]     iDATA,
    output logic              oREADY,
    output logic              oCMP_EN,
    output logic [IL-1:0]     oCMP_DATA,
    output logic [CNT_W-1:0]  oCNT,
    output logic [2:0]        oSTAGE,
    output logic              oCMP_CLR,
    input  logic              iBIT,
    output logic              oWVALID,
    output logic [PACK_W-1:0] oWDATA,
    input  logic              iWREADY,
    output logic              oBUSY,
    output logic              oDONE
);
    localparam int BW = $clog2(PACK_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIN   = CNT_W'(FRAME_LEN - 1);
    localparam logic [BW:0]      STALL_PEND = (BW + 1)'(PACK_W - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       stage_q, stage_d;
    logic             inflight_q, inflight_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ready, accept, wvalid;
    logic             pk_clr, pk_flush;
    logic [BW-1:0]    pk_cnt;
    logic [BW:0]      pend;

    // Bits already packed plus the one still in the comparator pipe.
    assign pend   = {1'b0, pk_cnt} + {{BW{1'b0}}, inflight_q};
    assign ready  = (state_q == ST_SCAN) && !iABORT &&
                    !(pend == STALL_PEND && wvalid && !iWREADY);
    assign accept = iVALID && ready;

    assign pk_clr   = iABORT || (state_q == ST_IDLE && iSTART);
    assign pk_flush = (state_q == ST_FLUSH) && !inflight_q;

    result_packer #(.PACK_W(PACK_W)) u_packer (
        .clk       (iCLK),
        .rst_n     (iRSTn),
        .clr       (pk_clr),
        .bit_vld   (inflight_q),
        .bit_in    (iBIT),
        .flush     (pk_flush),
        .out_ready (iWREADY),
        .bit_cnt   (pk_cnt),
        .out_valid (wvalid),
        .out_data  (oWDATA)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        inflight_d = accept;
        clr_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_SCAN;
                    stage_d = iSTAGE;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    if (cnt_q == LAST_BIN) state_d = ST_FLUSH;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && pk_cnt == '0 && (!wvalid || iWREADY))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase

        if (iABORT) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            inflight_d = 1'b0;
            clr_d      = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stage_q    <= '0;
            inflight_q <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            inflight_q <= inflight_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oREADY    = ready;
    assign oCMP_EN   = accept;
    assign oCMP_DATA = accept ? iDATA : '0;
    assign oCNT      = cnt_q;
    assign oSTAGE    = stage_q;
    assign oCMP_CLR  = clr_q;
    assign oWVALID   = wvalid;
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;

endmodule

// File: tb/tb_threshold_scan_ctrl.sv
// Randomized scoreboard bench: instance 0 uses 20-bin frames, instance 1 16-bin frames.
module tb_threshold_scan_ctrl;
    import threshold_scan_ctrl_pkg::*;

    localparam int IL  = 10;
    localparam int CW  = 17;
    localparam int PW  = 8;
    localparam int FLA = 20;
    localparam int FLB = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]         start, abort, valid, ibit, wready;
    logic [1:0][2:0]    stg_in;
    logic [1:0][IL-1:0] din;
    logic [1:0]         rdy, cen, cclr, wvld, busy, done;
    logic [1:0][IL-1:0] cdat;
    logic [1:0][CW-1:0] ocnt;
    logic [1:0][2:0]    ostg;
    logic [1:0][PW-1:0] wdat;

    threshold_scan_ctrl #(.IL(IL), .CNT_W(CW), .FRAME_LEN(FLA), .PACK_W(PW)) u_dut_a (
        .iCLK(clk), .iRSTn(rstn), .iSTART(start[0]), .iSTAGE(stg_in[0]), .iABORT(abort[0]),
        .iVALID(valid[0]), .iDATA(din[0]), .oREADY(rdy[0]), .oCMP_EN(cen[0]),
        .oCMP_DATA(cdat[0]), .oCNT(ocnt[0]), .oSTAGE(ostg[0]), .oCMP_CLR(cclr[0]),
        .iBIT(ibit[0]), .oWVALID(wvld[0]), .oWDATA(wdat[0]), .iWREADY(wready[0]),
        .oBUSY(busy[0]), .oDONE(done[0]));

    threshold_scan_ctrl #(.IL(IL), .CNT_W(CW), .FRAME_LEN(FLB), .PACK_W(PW)) u_dut_b (
        .iCLK(clk), .iRSTn(rstn), .iSTART(start[1]), .iSTAGE(stg_in[1]), .iABORT(abort[1]),
        .iVALID(valid[1]), .iDATA(din[1]), .oREADY(rdy[1]), .oCMP_EN(cen[1]),
        .oCMP_DATA(cdat[1]), .oCNT(ocnt[1]), .oSTAGE(ostg[1]), .oCMP_CLR(cclr[1]),
        .iBIT(ibit[1]), .oWVALID(wvld[1]), .oWDATA(wdat[1]), .iWREADY(wready[1]),
        .oBUSY(busy[1]), .oDONE(done[1]));

    int n_cmp = 0, n_bad = 0;
    int mode[2], exp_bin[2], done_seen[2], clr_seen[2];
    logic [2:0] exp_stage[2];
    bit prev_done[2], held[2];
    logic [PW-1:0] held_dat[2];
    logic [PW-1:0] q0[$], q1[$];
    int cyc_no = 0, stall_end = 0;
    bit rnd_wr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Comparator behaviour: one result bit per bin, chosen by test mode.
    function automatic logic bitfn(input int md, input logic [IL-1:0] d, input int bin);
        case (md)
            0:       return (bin % 2) == 0;
            1:       return 1'b1;
            default: return int'(d) > ((bin * 37) % 1024);
        endcase
    endfunction

    // Registered comparator model: answers the cycle after each oCMP_EN.
    initial begin
        logic [1:0] nxt;
        ibit = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                nxt[k] = cen[k] ? bitfn(mode[k], cdat[k], int'(ocnt[k])) : 1'($urandom);
            @(posedge clk);
            ibit <= nxt;
        end
    end

    initial begin
        wready = 2'b11;
        forever begin
            @(posedge clk); #1;
            cyc_no++;
            wready[0] = (cyc_no < stall_end) ? 1'b0 :
                        (rnd_wr ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int k = 0; k < 2; k++) begin
                    if (cen[k]) begin
                        chk("cnt", int'(ocnt[k]), exp_bin[k]);
                        chk("cmp_data", int'(cdat[k]), int'(din[k]));
                        chk("stage", int'(ostg[k]), int'(exp_stage[k]));
                        exp_bin[k]++;
                    end
                    if (held[k]) begin
                        chk("hold_valid", int'(wvld[k]), 1);
                        chk("hold_data", int'(wdat[k]), int'(held_dat[k]));
                    end
                    if (wvld[k] && wready[k]) begin
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                            n_cmp++; n_bad++;
                            $display("FAIL word_unexpected: inst %0d got 0x%0h expected none", k, wdat[k]);
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk("word", int'(wdat[k]), int'(e));
                        end
                    end
                    held[k]     = wvld[k] && !wready[k] && !abort[k];
                    held_dat[k] = wdat[k];
                    if (done[k]) begin
                        done_seen[k]++;
                        chk("done_one_cycle", int'(prev_done[k]), 0);
                    end
                    prev_done[k] = done[k];
                    if (cclr[k]) clr_seen[k]++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int k, input int md, input logic [2:0] st, input int abort_at,
                             input bit gaps, input int glitch_at, input bit stall_chk);
        int fl, nw, clr0, done0, budget;
        bit first_stall, lost;
        logic [IL-1:0] d[$];
        logic [PW-1:0] w;
        fl = (k == 0) ? FLA : FLB;
        first_stall = 1'b1;
        lost = 1'b0;
        mode[k] = md; exp_stage[k] = st; exp_bin[k] = 0;
        for (int b = 0; b < fl; b++) d.push_back(IL'($urandom));
        // Aborted frames only deliver words handshaken two cycles before the abort.
        nw = (abort_at < 0) ? (fl + PW - 1) / PW : (abort_at - 2) / PW;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int j = 0; j < PW; j++)
                if (wi * PW + j < fl) w[j] = bitfn(md, d[wi * PW + j], wi * PW + j);
            if (k == 0) q0.push_back(w); else q1.push_back(w);
        end
        clr0 = clr_seen[k]; done0 = done_seen[k];

        stg_in[k] = st; start[k] = 1'b1;
        cyc(1);
        start[k] = 1'b0; stg_in[k] = 3'($urandom);
        chk("busy_after_start", int'(busy[k]), 1);

        for (int b = 0; b < fl && !lost; b++) begin
            if (b == abort_at) begin
                valid[k] = 1'b1; din[k] = d[b]; abort[k] = 1'b1;
                @(negedge clk);
                chk("ready_during_abort", int'(rdy[k]), 0);
                cyc(1);
                abort[k] = 1'b0; valid[k] = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy[k]), 0);
                chk("abort_clr", int'(cclr[k]), 1);
                chk("abort_wvalid", int'(wvld[k]), 0);
                chk("abort_cnt", int'(ocnt[k]), 0);
                break;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid[k] = 1'b0; din[k] = IL'($urandom);
                cyc(1);
            end
            if (b == glitch_at) begin start[k] = 1'b1; stg_in[k] = ~st; end
            valid[k] = 1'b1; din[k] = d[b];
            budget = 0;
            forever begin
                @(negedge clk);
                if (rdy[k]) break;
                if (stall_chk && first_stall) begin
                    chk("ready_drop_after", b, 15);
                    first_stall = 1'b0;
                end
                budget++;
                if (budget > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ready_timeout: inst %0d bin %0d got no oREADY in 200 cycles", k, b);
                    lost = 1'b1;
                    break;
                end
            end
            cyc(1);
            start[k] = 1'b0;
            if (stall_chk && b == 2) stall_end = cyc_no + 30;
        end
        valid[k] = 1'b0;
        if (stall_chk) chk("ready_dropped", int'(first_stall), 0);

        budget = 0;
        while (busy[k] && budget < 400) begin @(negedge clk); budget++; end
        if (busy[k]) begin
            n_cmp++; n_bad++;
            $display("FAIL busy_timeout: inst %0d still busy after 400 cycles", k);
        end
        cyc(3);
        chk("done_pulses", done_seen[k] - done0, (abort_at < 0) ? 1 : 0);
        chk("clr_pulses", clr_seen[k] - clr0, (abort_at < 0) ? 1 : 2);
        chk("words_left", (k == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        rstn = 1'b0;
        start = 2'b11; abort = '0; valid = 2'b11; din = '1; stg_in = '1;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; exp_bin[k] = 0; done_seen[k] = 0; clr_seen[k] = 0;
            exp_stage[k] = '0; prev_done[k] = 1'b0; held[k] = 1'b0; held_dat[k] = '0;
        end
        cyc(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", int'(rdy[k]), 0);
            chk("rst_cmp_en", int'(cen[k]), 0);
            chk("rst_cmp_clr", int'(cclr[k]), 0);
            chk("rst_wvalid", int'(wvld[k]), 0);
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_done", int'(done[k]), 0);
            chk("rst_cnt", int'(ocnt[k]), 0);
            chk("rst_cmp_data", int'(cdat[k]), 0);
            chk("rst_wdata", int'(wdat[k]), 0);
            chk("rst_stage", int'(ostg[k]), 0);
        end
        start = '0; valid = '0;
        cyc(1);
        rstn = 1'b1;
        cyc(2);

        run_frame(0, 0, STAGE_TRACK, -1, 1'b0, 5, 1'b0);
        run_frame(0, 2, STAGE_FINE, -1, 1'b0, -1, 1'b1);
        run_frame(0, 0, STAGE_COARSE, 10, 1'b0, -1, 1'b0);
        run_frame(0, 2, STAGE_PEAK, -1, 1'b1, -1, 1'b0);
        run_frame(1, 1, STAGE_FINE, -1, 1'b0, -1, 1'b0);
        rnd_wr = 1'b1;
        for (int f = 0; f < 4; f++)
            run_frame(0, 2, 3'($urandom), -1, 1'b1, -1, 1'b0);
        rnd_wr = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/threshold_scan_ctrl.md
THRESHOLD_SCAN_CTRL -- requirements
Module: threshold_scan_ctrl

Interface
REQ-001 Parameter IL, default 10: magnitude sample width.
REQ-002 Parameter CNT_W, default 17: bin counter / threshold address width.
REQ-003 Parameter FRAME_LEN, default 16384: bins per frame, range 1..2^CNT_W.
REQ-004 Parameter PACK_W, default 8: binary results per output word.
REQ-005 One clock and one reset: iCLK input 1, rising-edge clock; iRSTn input 1, asynchronous active-low reset.
REQ-006 iSTART input 1: frame start request, sampled in IDLE only.
REQ-007 iSTAGE input 3: stage code, latched at start.
REQ-008 iABORT input 1: synchronous abort.
REQ-009 iVALID input 1, iDATA input IL: STFT magnitude stream.
REQ-010 oREADY output 1: sample accepted when iVALID && oREADY.
REQ-011 oCMP_EN output 1, oCMP_DATA output IL, oCNT output CNT_W, oSTAGE output 3, oCMP_CLR output 1: comparator drive.
REQ-012 iBIT input 1: comparator registered result.
REQ-013 oWVALID output 1, oWDATA output PACK_W, iWREADY input 1: packed result stream.
REQ-014 oBUSY output 1, oDONE output 1: status.

Function
REQ-015 FSM states: IDLE, SCAN, FLUSH, DONE.
REQ-016 IDLE -> SCAN on iSTART; oSTAGE <= iSTAGE, bin counter <= 0, oCMP_CLR pulses 1 cycle.
REQ-017 oREADY = 1 only in SCAN and when accepting a sample cannot overflow the packer (REQ-022).
REQ-018 On accept: oCMP_EN = 1, oCMP_DATA = iDATA, oCNT = current bin index, all combinational in the same cycle; counter increments after.
REQ-019 iBIT is valid exactly one cycle after each oCMP_EN pulse; the controller tracks one in-flight bit.
REQ-020 Bits pack LSB-first: first bin of each word lands in oWDATA[0].
REQ-021 Word complete after PACK_W bits -> moved to output register, oWVALID = 1; oWDATA/oWVALID held stable until iWREADY.
REQ-022 No result bit is ever dropped; oREADY is low whenever the packer holds PACK_W-1 bits (including in-flight) and oWVALID is high without iWREADY.
REQ-023 Acceptance of bin FRAME_LEN-1 -> FLUSH; counter does not wrap past FRAME_LEN-1.
REQ-024 FLUSH: wait for the in-flight bit; a partial word is zero-padded in the upper bits and emitted; an empty packer emits nothing.
REQ-025 FLUSH -> DONE once the last word is handshaken; DONE asserts oDONE for exactly 1 cycle, then goes to IDLE.
REQ-026 oBUSY = 1 in SCAN, FLUSH and DONE.
REQ-027 iSTART outside IDLE is ignored.
REQ-028 iABORT in any state -> IDLE next cycle; packer, output register and counter are cleared; oCMP_CLR pulses; no oDONE. iABORT has priority over iSTART and all handshakes.
REQ-029 A simultaneous word completion and iWREADY in the same cycle transfers without a bubble: back-to-back words at 1 word per PACK_W accepted samples.

Reset
REQ-030 While iRSTn = 0: state IDLE; oREADY, oCMP_EN, oCMP_CLR, oWVALID, oBUSY and oDONE are 0; oCNT, oCMP_DATA, oWDATA and oSTAGE are 0; the in-flight flag is cleared.
REQ-031 Reset deassertion mid-frame restarts from IDLE; no partial word is emitted.

Structure
REQ-032 Shared package holds the FSM state enum, the PACK_W and CNT_W defaults, and the stage code constants.
REQ-033 One sub-module, result_packer: shift register, bit count, output register and the valid/ready handshake.
REQ-034 No RAM; all storage is in flops.

Verification
REQ-035 Use FRAME_LEN=20, PACK_W=8 unless stated otherwise.
REQ-036 Reset with iWREADY=1: all outputs 0; oBUSY=0.
REQ-037 Start with iSTAGE=3'd5, 20 continuous samples, model iBIT alternating 1,0 -> oSTAGE=5; oCNT runs 0..19; words 0x55, 0x55, 0x05 (padded); one oDONE.
REQ-038 iWREADY=0 for 30 cycles mid-frame -> oREADY drops after 15 accepted samples; no bit lost; words match the model once released.
REQ-039 iABORT at bin 10 -> IDLE next cycle, oCMP_CLR pulse, no oDONE; a restart yields a correct full frame.
REQ-040 FRAME_LEN=16, iBIT all ones -> exactly 2 words 0xFF; no padding word emitted.
REQ-041 iSTART asserted during SCAN -> ignored; oSTAGE and oCNT remain unchanged.
